// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// FSM states, the zero register index and stage-enable bit order.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } ctrl_state_t;

    localparam logic [4:0] XZR = 5'd31;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_MEMWB = 4;
    localparam int NSTG      = 5;

endpackage

// File: rtl/reg_match.sv
// One source-vs-destination register compare, gated by the
// source-used flag; the zero register never matches.
module reg_match
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       used,
    input  logic [4:0] dst,
    output logic       hit
);

    assign hit = used && (src == dst) && (dst != XZR);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard controller: load-use stalls, branch squashes, data-memory
// freeze, plus saturating stall and flush counters.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int FL_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       idRn,
    input  logic [4:0]       idRm,
    input  logic             idUsesRn,
    input  logic             idUsesRm,
    input  logic [4:0]       exRd,
    input  logic             exIsLoad,
    input  logic             exRegWrite,
    input  logic             brTaken,
    input  logic             memReq,
    input  logic             memAck,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             idexWrite,
    output logic             exmemWrite,
    output logic             memwbWrite,
    output logic             idexBubble,
    output logic             ifidFlush,
    output logic [CNT_W-1:0] stallCycles,
    output logic [FL_W-1:0]  flushCount,
    output logic             busy
);

    ctrl_state_t     state;
    logic            rnHit;
    logic            rmHit;
    logic            loadUse;
    logic            freeze;
    logic [NSTG-1:0] wen;

    reg_match u_rn (
        .src  (idRn),
        .used (idUsesRn),
        .dst  (exRd),
        .hit  (rnHit)
    );

    reg_match u_rm (
        .src  (idRm),
        .used (idUsesRm),
        .dst  (exRd),
        .hit  (rmHit)
    );

    assign loadUse = exIsLoad & exRegWrite & (rnHit | rmHit);

    // An ack in the same cycle releases the freeze immediately.
    assign freeze = (memReq | (state == MEMWAIT)) & ~memAck;

    always_comb begin
        wen        = '1;
        idexBubble = 1'b0;
        ifidFlush  = 1'b0;
        unique case (1'b1)
            freeze: begin
                wen = '0;
            end
            (!freeze && brTaken): begin
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
            end
            (!freeze && !brTaken && loadUse): begin
                wen[STG_PC]   = 1'b0;
                wen[STG_IFID] = 1'b0;
                idexBubble    = 1'b1;
            end
            default: begin
                wen = '1;
            end
        endcase
    end

    assign pcWrite    = wen[STG_PC];
    assign ifidWrite  = wen[STG_IFID];
    assign idexWrite  = wen[STG_IDEX];
    assign exmemWrite = wen[STG_EXMEM];
    assign memwbWrite = wen[STG_MEMWB];
    assign busy       = (state == MEMWAIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= freeze ? MEMWAIT : RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCycles <= '0;
            flushCount  <= '0;
        end else begin
            if (!pcWrite && !(&stallCycles))
                stallCycles <= stallCycles + CNT_W'(1);
            if (ifidFlush && !(&flushCount))
                flushCount <= flushCount + FL_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: stimulus pushes expected responses, a negedge
// monitor pops and compares. Second instance uses 4-bit counters.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic       reset;
        logic [4:0] idRn;
        logic [4:0] idRm;
        logic       idUsesRn;
        logic       idUsesRm;
        logic [4:0] exRd;
        logic       exIsLoad;
        logic       exRegWrite;
        logic       brTaken;
        logic       memReq;
        logic       memAck;
    } stim_t;

    typedef struct packed {
        logic [4:0]  en;
        logic        bubble;
        logic        flush;
        logic        busy;
        logic [31:0] stall;
        logic [15:0] fcnt;
        logic [3:0]  stall4;
        logic [3:0]  fcnt4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  idRn = '0, idRm = '0, exRd = '0;
    logic        idUsesRn = 0, idUsesRm = 0;
    logic        exIsLoad = 0, exRegWrite = 0;
    logic        brTaken = 0, memReq = 0, memAck = 0;

    logic        pcWrite, ifidWrite, idexWrite, exmemWrite, memwbWrite;
    logic        idexBubble, ifidFlush, busy;
    logic [31:0] stallCycles;
    logic [15:0] flushCount;

    logic        pcWrite4, ifidWrite4, idexWrite4, exmemWrite4, memwbWrite4;
    logic        idexBubble4, ifidFlush4, busy4;
    logic [3:0]  stallCycles4;
    logic [3:0]  flushCount4;

    always #5 clk = ~clk;

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .idRn(idRn), .idRm(idRm),
        .idUsesRn(idUsesRn), .idUsesRm(idUsesRm),
        .exRd(exRd), .exIsLoad(exIsLoad), .exRegWrite(exRegWrite),
        .brTaken(brTaken), .memReq(memReq), .memAck(memAck),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite),
        .idexWrite(idexWrite), .exmemWrite(exmemWrite),
        .memwbWrite(memwbWrite), .idexBubble(idexBubble),
        .ifidFlush(ifidFlush), .stallCycles(stallCycles),
        .flushCount(flushCount), .busy(busy)
    );

    hazard_stall_ctrl #(.CNT_W(4), .FL_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .idRn(idRn), .idRm(idRm),
        .idUsesRn(idUsesRn), .idUsesRm(idUsesRm),
        .exRd(exRd), .exIsLoad(exIsLoad), .exRegWrite(exRegWrite),
        .brTaken(brTaken), .memReq(memReq), .memAck(memAck),
        .pcWrite(pcWrite4), .ifidWrite(ifidWrite4),
        .idexWrite(idexWrite4), .exmemWrite(exmemWrite4),
        .memwbWrite(memwbWrite4), .idexBubble(idexBubble4),
        .ifidFlush(ifidFlush4), .stallCycles(stallCycles4),
        .flushCount(flushCount4), .busy(busy4)
    );

    exp_t    sb[$];
    int      checks = 0;
    int      fails = 0;

    // Reference model state
    bit      waiting = 0;
    longint  nStall = 0;
    longint  nFlush = 0;

    function automatic longint sat(longint v, int w);
        longint mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        bit   lu, hold, pcw, fl;
        reset      = s.reset;
        idRn       = s.idRn;
        idRm       = s.idRm;
        idUsesRn   = s.idUsesRn;
        idUsesRm   = s.idUsesRm;
        exRd       = s.exRd;
        exIsLoad   = s.exIsLoad;
        exRegWrite = s.exRegWrite;
        brTaken    = s.brTaken;
        memReq     = s.memReq;
        memAck     = s.memAck;
        if (s.reset) begin
            waiting = 0;
            nStall  = 0;
            nFlush  = 0;
        end
        lu = s.exIsLoad && s.exRegWrite && s.exRd != 31 &&
             ((s.idUsesRn && s.idRn == s.exRd) ||
              (s.idUsesRm && s.idRm == s.exRd));
        hold = (waiting || s.memReq) && !s.memAck;
        e = '0;
        e.busy = waiting;
        if (hold) begin
            e.en = 5'b00000;
        end else if (s.brTaken) begin
            e.en     = 5'b11111;
            e.flush  = 1;
            e.bubble = 1;
        end else if (lu) begin
            e.en     = 5'b11100;
            e.bubble = 1;
        end else begin
            e.en = 5'b11111;
        end
        e.stall  = 32'(sat(nStall, 32));
        e.fcnt   = 16'(sat(nFlush, 16));
        e.stall4 = 4'(sat(nStall, 4));
        e.fcnt4  = 4'(sat(nFlush, 4));
        sb.push_back(e);
        pcw = e.en[0];
        fl  = e.flush;
        if (!s.reset) begin
            if (!pcw) nStall++;
            if (fl) nFlush++;
            waiting = hold;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("enables",
                    {memwbWrite, exmemWrite, idexWrite, ifidWrite, pcWrite},
                    e.en);
                chk("bubble", idexBubble, e.bubble);
                chk("flush", ifidFlush, e.flush);
                chk("busy", busy, e.busy);
                chk("stallCycles", stallCycles, e.stall);
                chk("flushCount", flushCount, e.fcnt);
                chk("stallCycles4", stallCycles4, e.stall4);
                chk("flushCount4", flushCount4, e.fcnt4);
            end
        end
    end

    initial begin : stim
        stim_t s;
        stim_t idle;
        int    guard;
        idle = '0;
        @(posedge clk);
        #1;
        s = idle; s.reset = 1;
        step(s);
        step(idle);
        // load-use on Rm, then bubble in EX
        s = idle;
        s.exIsLoad = 1; s.exRegWrite = 1; s.exRd = 5;
        s.idRm = 5; s.idUsesRm = 1;
        step(s);
        step(idle);
        // zero-register destination
        s = idle;
        s.exIsLoad = 1; s.exRegWrite = 1; s.exRd = 31;
        s.idRn = 31; s.idUsesRn = 1;
        step(s);
        // branch over a load-use hazard
        s = idle;
        s.exIsLoad = 1; s.exRegWrite = 1; s.exRd = 7;
        s.idRn = 7; s.idUsesRn = 1; s.brTaken = 1;
        step(s);
        step(idle);
        // memory wait, ack three cycles after request
        s = idle; s.memReq = 1;
        step(s);
        s = idle; s.brTaken = 1;
        step(s);
        step(idle);
        s = idle; s.memAck = 1;
        step(s);
        step(idle);
        // reset during memory wait
        s = idle; s.memReq = 1;
        step(s);
        step(idle);
        s = idle; s.reset = 1;
        step(s);
        step(idle);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            s = idle;
            s.reset      = ($urandom_range(0, 99) == 0);
            s.idRn       = ($urandom_range(0, 7) == 0) ? 5'd31
                                                       : 5'($urandom_range(0, 3));
            s.idRm       = 5'($urandom_range(0, 3));
            s.idUsesRn   = 1'($urandom);
            s.idUsesRm   = 1'($urandom);
            s.exRd       = ($urandom_range(0, 5) == 0) ? 5'd31
                                                       : 5'($urandom_range(0, 3));
            s.exIsLoad   = 1'($urandom);
            s.exRegWrite = ($urandom_range(0, 3) != 0);
            s.brTaken    = ($urandom_range(0, 4) == 0);
            s.memReq     = ($urandom_range(0, 5) == 0);
            s.memAck     = ($urandom_range(0, 3) == 0);
            step(s);
        end
        // long freeze to saturate the narrow stall counter
        s = idle; s.memReq = 1;
        for (int i = 0; i < 20; i++) step(s);
        s = idle; s.memAck = 1;
        step(s);
        step(idle);
        guard = 0;
        while (sb.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
